// File: rtl/med_pkg.sv
// Shared constants and FSM state encoding for the medicine frequency scheduler.
package med_pkg;

    localparam int ID_W_DEF   = 4;
    localparam int FREQ_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/med_freq_mem.sv
// Frequency register file: one write port, a registered read port for the entry
// controller and an asynchronous read port for the scan engine.
module med_freq_mem
    import med_pkg::*;
#(
    parameter int ID_W   = ID_W_DEF,
    parameter int FREQ_W = FREQ_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ID_W-1:0]   waddr,
    input  logic [FREQ_W-1:0] wdata,
    input  logic              re,
    input  logic [ID_W-1:0]   raddr,
    output logic [FREQ_W-1:0] rdata,
    output logic              rvalid,
    input  logic [ID_W-1:0]   saddr,
    output logic [FREQ_W-1:0] sdata
);

    localparam int DEPTH = 1 << ID_W;

    logic [FREQ_W-1:0] mem_q [DEPTH];
    logic [FREQ_W-1:0] mem_d [DEPTH];
    logic [FREQ_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;

    // Reads sample mem_q, so a same-cycle write to the read address returns the old value.
    always_comb begin
        mem_d    = mem_q;
        rdata_d  = rdata_q;
        rvalid_d = re;
        if (we) begin
            mem_d[waddr] = wdata;
        end
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign sdata  = mem_q[saddr];

endmodule

// File: rtl/med_freq_sched.sv
// Per-medicine reminder scheduler: each Tick walks the table, counts entries down
// and raises a valid/ack due event for every counter that expires.
module med_freq_sched
    import med_pkg::*;
#(
    parameter int ID_W   = ID_W_DEF,
    parameter int FREQ_W = FREQ_W_DEF
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Write_En,
    input  logic [ID_W-1:0]   MedIDIn,
    input  logic [FREQ_W-1:0] FreqIn,
    input  logic              Read_En,
    input  logic [ID_W-1:0]   R_MedID,
    output logic [FREQ_W-1:0] FreqOut,
    output logic              ReadValid,
    input  logic              Tick,
    output logic              DueValid,
    output logic [ID_W-1:0]   DueID,
    input  logic              DueAck,
    output logic              Busy,
    output logic              Overrun
);

    localparam int              DEPTH    = 1 << ID_W;
    localparam logic [ID_W-1:0] LAST_IDX = ID_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ID_W-1:0]   idx_q, idx_d;
    logic [ID_W-1:0]   due_id_q, due_id_d;
    logic              due_valid_q, due_valid_d;
    logic              overrun_q, overrun_d;
    logic [FREQ_W-1:0] cnt_q [DEPTH];
    logic [FREQ_W-1:0] cnt_d [DEPTH];
    logic [FREQ_W-1:0] scan_freq;
    logic              write_hit;

    med_freq_mem #(
        .ID_W   (ID_W),
        .FREQ_W (FREQ_W)
    ) u_mem (
        .clk    (Clk),
        .rst    (Rst),
        .we     (Write_En),
        .waddr  (MedIDIn),
        .wdata  (FreqIn),
        .re     (Read_En),
        .raddr  (R_MedID),
        .rdata  (FreqOut),
        .rvalid (ReadValid),
        .saddr  (idx_q),
        .sdata  (scan_freq)
    );

    assign write_hit = Write_En && (MedIDIn == idx_q);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        due_id_d    = due_id_q;
        due_valid_d = due_valid_q;
        overrun_d   = overrun_q;
        cnt_d       = cnt_q;

        case (state_q)
            IDLE: begin
                if (Tick) begin
                    state_d = SCAN;
                    idx_d   = '0;
                end
            end
            SCAN: begin
                if (Tick) begin
                    overrun_d = 1'b1;
                end
                // A counter of 0 on an enabled entry counts as expired.
                if (scan_freq != '0 && !write_hit && cnt_q[idx_q] <= FREQ_W'(1)) begin
                    cnt_d[idx_q] = scan_freq;
                    due_valid_d  = 1'b1;
                    due_id_d     = idx_q;
                    state_d      = HOLD;
                end else begin
                    if (scan_freq != '0 && !write_hit) begin
                        cnt_d[idx_q] = cnt_q[idx_q] - FREQ_W'(1);
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + ID_W'(1);
                    end
                end
            end
            HOLD: begin
                if (Tick) begin
                    overrun_d = 1'b1;
                end
                if (DueAck) begin
                    due_valid_d = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                    end else begin
                        state_d = SCAN;
                        idx_d   = idx_q + ID_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Entry writes override whatever the scan decided for the same counter.
        if (Write_En) begin
            cnt_d[MedIDIn] = FreqIn;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            due_id_q    <= '0;
            due_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            due_id_q    <= due_id_d;
            due_valid_q <= due_valid_d;
            overrun_q   <= overrun_d;
            cnt_q       <= cnt_d;
        end
    end

    assign DueValid = due_valid_q;
    assign DueID    = due_id_q;
    assign Busy     = (state_q != IDLE);
    assign Overrun  = overrun_q;

endmodule

// File: tb/tb_med_freq_sched.sv
// Directed bench for med_freq_sched: reads, event ordering, HOLD, overrun,
// write/scan collision and reset during HOLD.
module tb_med_freq_sched;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       Write_En = 1'b0;
    logic [3:0] MedIDIn = '0;
    logic [3:0] FreqIn = '0;
    logic       Read_En = 1'b0;
    logic [3:0] R_MedID = '0;
    logic [3:0] FreqOut;
    logic       ReadValid;
    logic       Tick = 1'b0;
    logic       DueValid;
    logic [3:0] DueID;
    logic       DueAck = 1'b0;
    logic       Busy;
    logic       Overrun;

    int checks = 0;
    int errors = 0;

    med_freq_sched #(.ID_W(4), .FREQ_W(4)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Write_En  (Write_En),
        .MedIDIn   (MedIDIn),
        .FreqIn    (FreqIn),
        .Read_En   (Read_En),
        .R_MedID   (R_MedID),
        .FreqOut   (FreqOut),
        .ReadValid (ReadValid),
        .Tick      (Tick),
        .DueValid  (DueValid),
        .DueID     (DueID),
        .DueAck    (DueAck),
        .Busy      (Busy),
        .Overrun   (Overrun)
    );

    always #5 Clk = ~Clk;

    task automatic do_reset();
        Write_En = 1'b0; Read_En = 1'b0; Tick = 1'b0; DueAck = 1'b0;
        Rst = 1'b1;
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
    endtask

    task automatic wr(input logic [3:0] id, input logic [3:0] f);
        Write_En = 1'b1; MedIDIn = id; FreqIn = f;
        @(negedge Clk);
        Write_En = 1'b0;
    endtask

    // Pulses Tick and follows the scan to completion, recording acked events.
    task automatic run_tick(output int n, output logic [3:0] ev [8],
                            output int busy_cyc, output bit done);
        n = 0; busy_cyc = 0; done = 1'b0;
        for (int i = 0; i < 8; i++) ev[i] = '0;
        Tick = 1'b1;
        @(negedge Clk);
        Tick = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (DueValid && DueAck) begin
                if (n < 8) ev[n] = DueID;
                n++;
            end
            if (!Busy) begin
                done = 1'b1;
                break;
            end
            busy_cyc++;
            @(negedge Clk);
        end
    endtask

    task automatic test_reset();
        int n, bc; bit done; logic [3:0] ev [8];
        #1 Rst = 1'b1;
        #2;
        checks++;
        if ({FreqOut, ReadValid, DueValid, DueID, Busy, Overrun} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: got FreqOut=%0d RV=%b DV=%b ID=%0d Busy=%b Ovr=%b, want all 0",
                     FreqOut, ReadValid, DueValid, DueID, Busy, Overrun);
        end
        @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
        DueAck = 1'b1;
        run_tick(n, ev, bc, done);
        checks++;
        if (!done || bc !== 16 || n !== 0) begin
            errors++;
            $display("FAIL empty_scan: done=%b busy_cycles=%0d events=%0d, want done=1 busy_cycles=16 events=0",
                     done, bc, n);
        end
        DueAck = 1'b0;
    endtask

    task automatic test_read();
        do_reset();
        wr(4'd3, 4'd2);
        Read_En = 1'b1; R_MedID = 4'd3;
        #1;
        checks++;
        if (ReadValid !== 1'b0) begin
            errors++;
            $display("FAIL read_early: ReadValid=%b before edge, want 0", ReadValid);
        end
        @(negedge Clk);
        Read_En = 1'b0;
        checks++;
        if (FreqOut !== 4'd2 || ReadValid !== 1'b1) begin
            errors++;
            $display("FAIL read_id3: FreqOut=%0d RV=%b, want 2 1", FreqOut, ReadValid);
        end
        @(negedge Clk);
        checks++;
        if (FreqOut !== 4'd2 || ReadValid !== 1'b0) begin
            errors++;
            $display("FAIL read_hold: FreqOut=%0d RV=%b, want 2 0", FreqOut, ReadValid);
        end
        Read_En = 1'b1; R_MedID = 4'd5;
        @(negedge Clk);
        Read_En = 1'b0;
        checks++;
        if (FreqOut !== 4'd0 || ReadValid !== 1'b1) begin
            errors++;
            $display("FAIL read_id5: FreqOut=%0d RV=%b, want 0 1", FreqOut, ReadValid);
        end
        Read_En = 1'b1; R_MedID = 4'd3;
        Write_En = 1'b1; MedIDIn = 4'd3; FreqIn = 4'd9;
        @(negedge Clk);
        Write_En = 1'b0;
        checks++;
        if (FreqOut !== 4'd2) begin
            errors++;
            $display("FAIL read_before_write: FreqOut=%0d, want 2", FreqOut);
        end
        @(negedge Clk);
        Read_En = 1'b0;
        checks++;
        if (FreqOut !== 4'd9) begin
            errors++;
            $display("FAIL read_after_write: FreqOut=%0d, want 9", FreqOut);
        end
    endtask

    task automatic test_event_order();
        int n, bc; bit done; logic [3:0] ev [8];
        do_reset();
        wr(4'd3, 4'd2);
        wr(4'd7, 4'd1);
        DueAck = 1'b1;
        run_tick(n, ev, bc, done);
        checks++;
        if (!done || n !== 1 || ev[0] !== 4'd7) begin
            errors++;
            $display("FAIL tick1_events: done=%b n=%0d first=%0d, want done=1 n=1 first=7", done, n, ev[0]);
        end
        run_tick(n, ev, bc, done);
        checks++;
        if (!done || n !== 2 || ev[0] !== 4'd3 || ev[1] !== 4'd7) begin
            errors++;
            $display("FAIL tick2_events: done=%b n=%0d ev=%0d,%0d, want done=1 n=2 ev=3,7",
                     done, n, ev[0], ev[1]);
        end
        DueAck = 1'b0;
    endtask

    task automatic test_hold();
        int bad, bc;
        do_reset();
        wr(4'd0, 4'd1);
        DueAck = 1'b0;
        Tick = 1'b1;
        @(negedge Clk);
        Tick = 1'b0;
        @(negedge Clk);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            if (DueValid !== 1'b1 || DueID !== 4'd0 || Busy !== 1'b1) bad++;
            if (c == 5) begin
                Write_En = 1'b1; MedIDIn = 4'd0; FreqIn = 4'd5;
            end
            @(negedge Clk);
            Write_En = 1'b0;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL hold_stable: %0d unstable cycles (DV=%b ID=%0d Busy=%b), want 0", bad, DueValid, DueID, Busy);
        end
        DueAck = 1'b1;
        @(negedge Clk);
        DueAck = 1'b0;
        checks++;
        if (DueValid !== 1'b0 || Busy !== 1'b1) begin
            errors++;
            $display("FAIL hold_ack: DV=%b Busy=%b, want 0 1", DueValid, Busy);
        end
        bc = 0;
        for (int c = 0; c < 40; c++) begin
            if (!Busy) break;
            bc++;
            @(negedge Clk);
        end
        checks++;
        if (bc !== 15) begin
            errors++;
            $display("FAIL hold_resume: busy cycles after ack=%0d, want 15", bc);
        end
    endtask

    task automatic test_overrun();
        int n, bc; bit done, saw; logic [3:0] ev [8];
        do_reset();
        wr(4'd0, 4'd2);
        DueAck = 1'b1;
        saw = 1'b0;
        Tick = 1'b1;
        @(negedge Clk);
        Tick = 1'b0;
        repeat (3) @(negedge Clk);
        Tick = 1'b1;
        @(negedge Clk);
        Tick = 1'b0;
        checks++;
        if (Overrun !== 1'b1 || Busy !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: Overrun=%b Busy=%b, want 1 1", Overrun, Busy);
        end
        for (int c = 0; c < 40 && Busy; c++) begin
            if (DueValid) saw = 1'b1;
            @(negedge Clk);
        end
        checks++;
        if (saw !== 1'b0 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL overrun_single_decrement: event_seen=%b Busy=%b, want 0 0", saw, Busy);
        end
        run_tick(n, ev, bc, done);
        checks++;
        if (!done || n !== 1 || ev[0] !== 4'd0 || Overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_next_tick: done=%b n=%0d id=%0d Overrun=%b, want 1 1 0 1",
                     done, n, ev[0], Overrun);
        end
        DueAck = 1'b0;
    endtask

    task automatic test_write_collision();
        int n0, n1, n2, bc; bit d0, d1, d2, saw; logic [3:0] ev [8];
        do_reset();
        wr(4'd4, 4'd1);
        DueAck = 1'b1;
        saw = 1'b0;
        Tick = 1'b1;
        @(negedge Clk);
        Tick = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (DueValid) saw = 1'b1;
            @(negedge Clk);
        end
        Write_En = 1'b1; MedIDIn = 4'd4; FreqIn = 4'd3;
        @(negedge Clk);
        Write_En = 1'b0;
        for (int c = 0; c < 40 && Busy; c++) begin
            if (DueValid) saw = 1'b1;
            @(negedge Clk);
        end
        checks++;
        if (saw !== 1'b0 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL collision_no_event: event_seen=%b Busy=%b, want 0 0", saw, Busy);
        end
        run_tick(n0, ev, bc, d0);
        run_tick(n1, ev, bc, d1);
        run_tick(n2, ev, bc, d2);
        checks++;
        if (!(d0 && d1 && d2) || n0 !== 0 || n1 !== 0 || n2 !== 1 || ev[0] !== 4'd4) begin
            errors++;
            $display("FAIL collision_reload: events per tick=%0d,%0d,%0d id=%0d, want 0,0,1 id=4",
                     n0, n1, n2, ev[0]);
        end
        DueAck = 1'b0;
    endtask

    task automatic test_reset_in_hold();
        int n, bc; bit done, seen; logic [3:0] ev [8];
        do_reset();
        wr(4'd2, 4'd1);
        DueAck = 1'b0;
        seen = 1'b0;
        Tick = 1'b1;
        @(negedge Clk);
        Tick = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (DueValid) begin
                seen = 1'b1;
                break;
            end
            @(negedge Clk);
        end
        checks++;
        if (!seen || DueID !== 4'd2) begin
            errors++;
            $display("FAIL hold_reached: seen=%b DueID=%0d, want 1 2", seen, DueID);
        end
        #2 Rst = 1'b1;
        #1;
        checks++;
        if (DueValid !== 1'b0 || Busy !== 1'b0 || DueID !== 4'd0) begin
            errors++;
            $display("FAIL async_reset_hold: DV=%b Busy=%b ID=%0d, want 0 0 0", DueValid, Busy, DueID);
        end
        @(negedge Clk);
        Rst = 1'b0;
        Read_En = 1'b1; R_MedID = 4'd2;
        @(negedge Clk);
        Read_En = 1'b0;
        checks++;
        if (FreqOut !== 4'd0 || ReadValid !== 1'b1) begin
            errors++;
            $display("FAIL reset_cleared_entry: FreqOut=%0d RV=%b, want 0 1", FreqOut, ReadValid);
        end
        DueAck = 1'b1;
        run_tick(n, ev, bc, done);
        checks++;
        if (!done || n !== 0) begin
            errors++;
            $display("FAIL post_reset_tick: done=%b events=%0d, want 1 0", done, n);
        end
        DueAck = 1'b0;
    endtask

    initial begin
        test_reset();
        test_read();
        test_event_order();
        test_hold();
        test_overrun();
        test_write_collision();
        test_reset_in_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/med_freq_sched.md
Name: med_freq_sched

Overview:
- Parametrised successor to the single-port medicine frequency store.
- Holds one reminder frequency per medicine ID, plus a per-entry countdown counter.
- On each scheduler tick, a scan engine walks every entry and decrements its counter. When a counter expires it raises a "dose due" event carrying the medicine ID, using a valid/ack handshake.
- Sits between the medicine-entry controller (writes and reads) and the alert/display logic (consumes due events).

Parameters:
- ID_W, 4, medicine ID width; table depth is 2**ID_W.
- FREQ_W, 4, frequency/counter width, in ticks; 0 means the entry is disabled.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  asynchronous, active-high reset.
- Write_En  in  1  write FreqIn to entry MedIDIn.
- MedIDIn  in  ID_W  write address.
- FreqIn  in  FREQ_W  frequency to store.
- Read_En  in  1  read request.
- R_MedID  in  ID_W  read address.
- FreqOut  out  FREQ_W  stored frequency of R_MedID.
- ReadValid  out  1  FreqOut valid strobe.
- Tick  in  1  one-cycle scheduler pulse (e.g. 1 per minute).
- DueValid  out  1  due event pending.
- DueID  out  ID_W  medicine ID of the pending event.
- DueAck  in  1  consumer accepts the event.
- Busy  out  1  scan in progress (state != IDLE).
- Overrun  out  1  sticky: a Tick arrived while Busy.

Behaviour:
- Reset (async, Rst=1):
  - All freq entries and counters cleared to 0.
  - FreqOut=0, ReadValid=0, DueValid=0, DueID=0, Busy=0, Overrun=0; FSM goes to IDLE.
  - Reset mid-scan or mid-HOLD abandons the scan and drops DueValid immediately.
- Write:
  - Write_En=1 at edge: freq[MedIDIn] <= FreqIn and cnt[MedIDIn] <= FreqIn (counter reload).
  - FreqIn=0 disables the entry.
  - Writes are accepted in every FSM state.
- Read:
  - Read_En=1 at edge N: FreqOut = freq[R_MedID] and ReadValid=1 after edge N; 1-cycle latency.
  - ReadValid is 0 when Read_En was 0; FreqOut holds its last value.
  - Read and write to the same ID in the same cycle return the OLD value (read-before-write).
- FSM states:
  - IDLE: Tick=1 -> SCAN with idx=0.
  - SCAN: processes entry idx, one entry per cycle.
    - If freq[idx]==0: skip.
    - Else if cnt[idx]==1: cnt[idx] <= freq[idx]; DueValid <= 1, DueID <= idx; go to HOLD.
    - Else: cnt[idx] <= cnt[idx]-1.
    - If idx==2**ID_W-1 and no event fired: go to IDLE. Otherwise idx <= idx+1; no wrap within a scan.
  - HOLD: DueValid held and DueID stable until DueAck=1 at an edge.
    - On ack: DueValid <= 0.
    - Then go to IDLE if idx was the last entry, else back to SCAN with idx+1.
    - DueAck while DueValid=0 is ignored.
- Latency: with no events, a full scan is 2**ID_W cycles after the Tick edge.
- Simultaneous write and scan on the same idx:
  - The write wins; the scan's decrement/reload for that entry is discarded and no event fires for it.
  - If that entry already has a pending event in HOLD, the event stays valid.
- Tick while Busy: the tick is dropped and Overrun <= 1. Overrun is cleared only by Rst.
- Counter arithmetic: unsigned FREQ_W. Counter value 0 with nonzero freq (not reachable after a write) is treated as 1, i.e. fires this tick.

Decomposition:
- Shared package med_pkg:
  - constants ID_W_DEF, FREQ_W_DEF;
  - state enum {IDLE, SCAN, HOLD}.
- One natural sub-module: med_freq_mem, a 2**ID_W x FREQ_W dual-port register file.
  - Write port plus registered read port for external reads.
  - Second asynchronous read port for the scan engine.
- Counters and FSM live in the top.

Test Plan:
- Reset, then write ID3=2, then Read_En ID3 -> FreqOut=2 with ReadValid=1 exactly one cycle later; unwritten ID5 reads 0.
- ID3=2, ID7=1, DueAck tied 1 -> tick1: event ID7 only; tick2: events ID3 then ID7, in ascending order.
- ID0=1, DueAck held 0 for 10 cycles -> DueValid=1, DueID=0 stable, Busy=1; ack -> remaining entries scanned, Busy falls.
- Second Tick during scan -> Overrun=1 persists; the counters show only one decrement.
- Write ID4=3 in the same cycle the scan visits ID4 (cnt=1) -> no event; cnt=3; fires on the 3rd subsequent tick.
- Rst asserted in HOLD -> DueValid, Busy and all entries 0 asynchronously; a later Tick produces no events.
